// File: rtl/stream_maxmin_reduce.sv
// stream_maxmin_reduce
//
// Reduces a valid/ready stream of WIDTH-bit elements, framed by a last flag, to
// one extreme value (max or min, signed or unsigned). It also reports where that
// value sat in the frame and how many beats the frame had.
//
// Optional build macro:
//   STREAM_MAXMIN_REG_IN_EN - inserts an input register slice with a skid buffer.
//                             in_ready then depends only on skid occupancy, and
//                             result latency grows from 1 to 2 cycles. Results
//                             and ordering are unchanged.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   mode_min      0 = max, 1 = min (taken from the first beat of a frame)
//   mode_signed   0 = unsigned, 1 = two's-complement (taken from the first beat)
//   in_valid/in_ready/in_data/in_last   input element stream
//   out_valid/out_ready                 result handshake
//   out_data      selected extreme element
//   out_idx       zero-based frame position of out_data
//   out_count     beats in frame, modulo 2^IDX_W
//   out_ovf       frame exceeded 2^IDX_W-1 beats
//   busy          frame in progress
module stream_maxmin_reduce #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_min,
    input  logic             mode_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    localparam logic [WIDTH-1:0] MsbMask = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] CntMax  = '1;

    // Beat presented to the reduction core
    logic             c_valid;
    logic             c_ready;
    logic [WIDTH-1:0] c_data;
    logic             c_last;
    logic             c_min;
    logic             c_signed;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [IDX_W-1:0] acc_idx_q;
    logic [IDX_W-1:0] cnt_q;
    logic             ovf_q;
    logic             min_q;
    logic             signed_q;

    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [IDX_W-1:0] out_count_q;
    logic             out_ovf_q;

    logic             take;
    logic             first;

    // The result register may be refilled in the cycle it is consumed
    assign c_ready = (state_q != StHold) | out_ready;
    assign take    = c_valid & c_ready;
    assign first   = (state_q != StAcc);

`ifdef STREAM_MAXMIN_REG_IN_EN
    // Pipe register plus one skid entry; in_ready comes straight from a flop
    localparam int unsigned PW = WIDTH + 3;

    logic          pv_q, sv_q;
    logic [PW-1:0] p_q, s_q;
    logic [PW-1:0] in_pl;
    logic          in_take;

    assign in_pl    = {mode_signed, mode_min, in_last, in_data};
    assign in_ready = ~sv_q;
    assign in_take  = in_valid & ~sv_q;

    assign c_valid  = pv_q;
    assign c_data   = p_q[WIDTH-1:0];
    assign c_last   = p_q[WIDTH];
    assign c_min    = p_q[WIDTH+1];
    assign c_signed = p_q[WIDTH+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= 1'b0;
            sv_q <= 1'b0;
            p_q  <= '0;
            s_q  <= '0;
        end else if (!pv_q || take) begin
            // Pipe slot frees up: drain skid first to keep beat order
            if (sv_q) begin
                p_q  <= s_q;
                pv_q <= 1'b1;
                sv_q <= 1'b0;
            end else if (in_take) begin
                p_q  <= in_pl;
                pv_q <= 1'b1;
            end else begin
                pv_q <= 1'b0;
            end
        end else if (in_take) begin
            s_q  <= in_pl;
            sv_q <= 1'b1;
        end
    end
`else
    assign c_valid  = in_valid;
    assign c_data   = in_data;
    assign c_last   = in_last;
    assign c_min    = mode_min;
    assign c_signed = mode_signed;
    assign in_ready = c_ready;
`endif

    // Merge the current beat with the accumulator
    logic             eff_min;
    logic             eff_signed;
    logic [WIDTH-1:0] cand_key;
    logic [WIDTH-1:0] acc_key;
    logic [WIDTH:0]   diff;
    logic             better;
    logic [WIDTH-1:0] m_data;
    logic [IDX_W-1:0] m_idx;
    logic [IDX_W-1:0] m_cnt;
    logic             m_ovf;

    always_comb begin
        eff_min    = first ? c_min : min_q;
        eff_signed = first ? c_signed : signed_q;
        // Flipping the MSB maps two's-complement order onto unsigned order
        cand_key   = c_data ^ (eff_signed ? MsbMask : '0);
        acc_key    = acc_q ^ (eff_signed ? MsbMask : '0);
        // Borrow out of (a - b) means a < b; strict, so ties keep the earlier index
        if (eff_min) begin
            diff = {1'b0, cand_key} - {1'b0, acc_key};
        end else begin
            diff = {1'b0, acc_key} - {1'b0, cand_key};
        end
        better = diff[WIDTH];

        if (first) begin
            m_data = c_data;
            m_idx  = '0;
            m_cnt  = IDX_W'(1);
            m_ovf  = 1'b0;
        end else begin
            m_data = better ? c_data : acc_q;
            m_idx  = better ? cnt_q : acc_idx_q;
            m_cnt  = cnt_q + IDX_W'(1);
            m_ovf  = ovf_q | (cnt_q == CntMax);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (take) state_d = c_last ? StHold : StAcc;
            end
            StAcc: begin
                if (take && c_last) state_d = StHold;
            end
            StHold: begin
                if (take) begin
                    state_d = c_last ? StHold : StAcc;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            acc_idx_q   <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            min_q       <= 1'b0;
            signed_q    <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == StHold);
            busy_q      <= (state_d == StAcc);
            if (take) begin
                if (first) begin
                    min_q    <= c_min;
                    signed_q <= c_signed;
                end
                if (c_last) begin
                    out_data_q  <= m_data;
                    out_idx_q   <= m_idx;
                    out_count_q <= m_cnt;
                    out_ovf_q   <= m_ovf;
                end else begin
                    acc_q     <= m_data;
                    acc_idx_q <= m_idx;
                    cnt_q     <= m_cnt;
                    ovf_q     <= m_ovf;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_stream_maxmin_reduce.sv
// Bench for stream_maxmin_reduce: instance a (WIDTH=32, IDX_W=16) and
// instance b (WIDTH=8, IDX_W=2). Expected results are queued as frames are sent
// and popped by per-instance monitors when a result handshake is presented.
module tb_stream_maxmin_reduce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] idx;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_vec = 0;
    int n_err = 0;

    // Instance a
    logic        a_min = 0, a_sgn = 0, a_valid = 0, a_last = 0, a_oready = 0;
    logic [31:0] a_data = '0;
    logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
    logic [31:0] a_out_data;
    logic [15:0] a_out_idx, a_out_count;

    stream_maxmin_reduce #(.WIDTH(32), .IDX_W(16)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .mode_min   (a_min),
        .mode_signed(a_sgn),
        .in_valid   (a_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_data),
        .in_last    (a_last),
        .out_valid  (a_out_valid),
        .out_ready  (a_oready),
        .out_data   (a_out_data),
        .out_idx    (a_out_idx),
        .out_count  (a_out_count),
        .out_ovf    (a_out_ovf),
        .busy       (a_busy)
    );

    // Instance b
    logic       b_min = 0, b_sgn = 0, b_valid = 0, b_last = 0, b_oready = 1;
    logic [7:0] b_data = '0;
    logic       b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [7:0] b_out_data;
    logic [1:0] b_out_idx, b_out_count;

    stream_maxmin_reduce #(.WIDTH(8), .IDX_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .mode_min   (b_min),
        .mode_signed(b_sgn),
        .in_valid   (b_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_data),
        .in_last    (b_last),
        .out_valid  (b_out_valid),
        .out_ready  (b_oready),
        .out_data   (b_out_data),
        .out_idx    (b_out_idx),
        .out_count  (b_out_count),
        .out_ovf    (b_out_ovf),
        .busy       (b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [15:0] i,
                                input logic [15:0] c, input logic o);
        exp_t e;
        e.data = d;
        e.idx  = i;
        e.cnt  = c;
        e.ovf  = o;
        return e;
    endfunction

    // Handshake is sampled at the negedge; inputs only change just after posedge
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_oready) begin
            if (exp_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_unexpected: got result %0h, expected none", a_out_data);
            end else begin
                exp_t e;
                e = exp_a.pop_front();
                chk("a_data", a_out_data, e.data);
                chk("a_idx", 32'(a_out_idx), 32'(e.idx));
                chk("a_count", 32'(a_out_count), 32'(e.cnt));
                chk("a_ovf", 32'(a_out_ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_oready) begin
            if (exp_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_unexpected: got result %0h, expected none", b_out_data);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                chk("b_data", 32'(b_out_data), e.data);
                chk("b_idx", 32'(b_out_idx), 32'(e.idx));
                chk("b_count", 32'(b_out_count), 32'(e.cnt));
                chk("b_ovf", 32'(b_out_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic beat_a(input logic [31:0] d, input logic l, input logic mn, input logic sg);
        int guard;
        guard   = 0;
        a_valid = 1'b1;
        a_data  = d;
        a_last  = l;
        a_min   = mn;
        a_sgn   = sg;
        @(negedge clk);
        while (!a_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!a_in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL a_accept: in_ready got 0, expected 1");
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] d, input logic l, input logic mn, input logic sg);
        int guard;
        guard   = 0;
        b_valid = 1'b1;
        b_data  = d;
        b_last  = l;
        b_min   = mn;
        b_sgn   = sg;
        @(negedge clk);
        while (!b_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!b_in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL b_accept: in_ready got 0, expected 1");
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    initial begin
        int guard;

        // Reset state
        @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_out_idx", 32'(a_out_idx), 32'd0);
        chk("rst_out_count", 32'(a_out_count), 32'd0);
        chk("rst_out_ovf", 32'(a_out_ovf), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // b: signed min, then unsigned min, of {0x10, 0x80, 0x7F}
        exp_b.push_back(mk(32'h80, 16'd1, 16'd3, 1'b0));
        beat_b(8'h10, 0, 1, 1);
        beat_b(8'h80, 0, 1, 1);
        beat_b(8'h7F, 1, 1, 1);
        exp_b.push_back(mk(32'h10, 16'd0, 16'd3, 1'b0));
        beat_b(8'h10, 0, 1, 0);
        beat_b(8'h80, 0, 1, 0);
        beat_b(8'h7F, 1, 1, 0);
        // b: counter wrap with IDX_W=2
        exp_b.push_back(mk(32'h4, 16'd3, 16'd1, 1'b1));
        beat_b(8'd1, 0, 0, 0);
        beat_b(8'd2, 0, 0, 0);
        beat_b(8'd3, 0, 0, 0);
        beat_b(8'd4, 0, 0, 0);
        beat_b(8'd0, 1, 0, 0);
        // Overflow must not leak into the next frame
        exp_b.push_back(mk(32'h5, 16'd0, 16'd1, 1'b0));
        beat_b(8'd5, 1, 0, 0);

        // a: unsigned max with a tie at the maximum
        a_oready = 1'b1;
        exp_a.push_back(mk(32'hFFFF_FFFE, 16'd1, 16'd4, 1'b0));
        beat_a(32'd5, 0, 0, 0);
        chk("busy_in_frame", 32'(a_busy), 32'd1);
        beat_a(32'hFFFF_FFFE, 0, 0, 0);
        beat_a(32'd7, 0, 0, 0);
        beat_a(32'hFFFF_FFFE, 1, 0, 0);
        chk("latency_valid", 32'(a_out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("released_valid", 32'(a_out_valid), 32'd0);

        // Single-beat frame held by back-pressure
        a_oready = 1'b0;
        exp_a.push_back(mk(32'h1234, 16'd0, 16'd1, 1'b0));
        beat_a(32'h1234, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(a_out_valid), 32'd1);
            chk("hold_data", a_out_data, 32'h1234);
            chk("hold_in_ready", 32'(a_in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        a_oready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", 32'(a_out_valid), 32'd0);

        // Back-to-back: new first beat accepted in the result handshake cycle
        a_oready = 1'b0;
        exp_a.push_back(mk(32'd20, 16'd0, 16'd1, 1'b0));
        beat_a(32'd20, 1, 0, 0);
        a_oready = 1'b1;
        beat_a(32'd9, 0, 0, 0);
        chk("b2b_busy", 32'(a_busy), 32'd1);
        chk("b2b_valid", 32'(a_out_valid), 32'd0);
        exp_a.push_back(mk(32'd9, 16'd0, 16'd2, 1'b0));
        beat_a(32'd3, 1, 0, 0);

        // Mode inputs ignored after the first beat
        exp_a.push_back(mk(32'd8, 16'd1, 16'd3, 1'b0));
        beat_a(32'd3, 0, 0, 0);
        beat_a(32'd8, 0, 1, 1);
        beat_a(32'd2, 1, 1, 1);

        // Ties under min keep the lowest index
        exp_a.push_back(mk(32'd7, 16'd0, 16'd3, 1'b0));
        beat_a(32'd7, 0, 1, 0);
        beat_a(32'd7, 0, 1, 0);
        beat_a(32'd7, 1, 1, 0);

        // Signed max at 32 bits
        exp_a.push_back(mk(32'h7FFF_FFFF, 16'd1, 16'd3, 1'b0));
        beat_a(32'h8000_0000, 0, 0, 1);
        beat_a(32'h7FFF_FFFF, 0, 0, 1);
        beat_a(32'hFFFF_FFFF, 1, 0, 1);

        // Reset mid-frame discards the partial frame
        @(posedge clk);
        #1;
        beat_a(32'd11, 0, 0, 0);
        beat_a(32'd12, 0, 0, 0);
        rst = 1'b1;
        #2;
        chk("midrst_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_busy", 32'(a_busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_a.push_back(mk(32'd6, 16'd0, 16'd1, 1'b0));
        beat_a(32'd6, 1, 0, 0);

        // Drain both scoreboards within a bounded time
        guard = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("pending_a", 32'(exp_a.size()), 32'd0);
        chk("pending_b", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_maxmin_reduce.md
Name: stream_maxmin_reduce

Overview:
Parametrised sequential successor to the team's combinational 32-bit unsigned max selector. It reduces a valid/ready stream of WIDTH-bit elements, framed by a last flag, to a single extreme value: the maximum or the minimum, compared as signed or unsigned. It also returns the position of that value and the beat count. It sits between a streaming datapath producer and a result consumer in the FHE-benchmark evaluation flow.

Parameters:
WIDTH  32  element width in bits (>=2)
IDX_W  16  width of the element index and beat counter

Ports:
clk          in   1       rising-edge clock
rst          in   1       asynchronous active-high reset
mode_min     in   1       0 = select max, 1 = select min; sampled on first beat of frame
mode_signed  in   1       0 = unsigned compare, 1 = two's-complement compare; sampled on first beat
in_valid     in   1       input beat valid
in_ready     out  1       input beat accepted when in_valid & in_ready
in_data      in   WIDTH   element
in_last      in   1       final beat of frame
out_valid    out  1       result valid
out_ready    in   1       result consumed when out_valid & out_ready
out_data     out  WIDTH   selected extreme element
out_idx      out  IDX_W   zero-based frame position of selected element
out_count    out  IDX_W   beats in frame (modulo 2^IDX_W)
out_ovf      out  1       frame exceeded 2^IDX_W-1 beats
busy         out  1       frame in progress (state ACC)

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high, on rst.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_idx=0, out_count=0, out_ovf=0, busy=0. Accumulator, index counter, and latched mode bits are all cleared.
- FSM states: IDLE (no frame open), ACC (frame open), HOLD (result pending, out_valid=1).
- Ready rule: in_ready = (state != HOLD) | out_ready. This lets the next frame's first beat be accepted in the same cycle as the result handshake.
- First beat of a frame (accepted in IDLE or HOLD):
  - Latch mode_min and mode_signed.
  - Load acc=in_data, acc_idx=0, cnt=1, ovf=0.
  - If in_last=0, go to ACC.
- Later beat in ACC: replace acc/acc_idx with in_data/cnt only if the candidate is strictly better.
  - Better means greater for max, less for min, under the latched signedness.
  - Ties keep the earlier element, so the lowest index wins.
  - cnt increments and wraps to 0 past all-ones. A wrap sets ovf, which stays sticky for the rest of the frame.
- Beat with in_last=1:
  - The combined result (acc vs current beat, or the beat alone if it is the first) is registered into out_data/out_idx/out_count/out_ovf.
  - State goes to HOLD; out_valid=1 on the next cycle. Latency is 1 cycle from last-beat acceptance.
- HOLD:
  - Outputs are held stable until out_ready.
  - On handshake with no new beat: go IDLE, out_valid=0 next cycle.
  - On handshake with a simultaneous new first beat: start the new frame. It goes to ACC, or stays in HOLD with the new result if that beat also has in_last=1.
- Mode inputs are ignored except on a first beat. Changing them mid-frame has no effect.
- Single-beat frame: out_data=element, out_idx=0, out_count=1.
- Comparison: implemented as subtraction-based compare. Signed mode flips the MSB of both operands before an unsigned compare.
- Reset mid-frame or during HOLD: the partial frame or pending result is discarded, with no output.
- busy=1 exactly while state==ACC.

Optional Feature:
- Macro: STREAM_MAXMIN_REG_IN_EN.
- When defined: an input register slice with a skid buffer is inserted.
  - in_ready is registered: it depends only on skid occupancy, not on out_ready.
  - Result latency becomes 2 cycles from last-beat acceptance.
  - Throughput stays 1 beat/cycle.
- When undefined: direct path as above, latency 1.
- Functional results and ordering are identical in both builds.

Test Plan:
- Unsigned max, WIDTH=32: frame {5, 0xFFFF_FFFE, 7, 0xFFFF_FFFE(last)} -> out_data=0xFFFF_FFFE, out_idx=1, out_count=4, out_ovf=0, out_valid one cycle after last beat.
- Signed min, WIDTH=8: frame {0x10, 0x80, 0x7F(last)} -> out_data=0x80 (-128), out_idx=1. The same frame in unsigned min -> out_data=0x10, out_idx=0.
- Single-beat frame 0x1234 with in_last=1 and out_ready held 0 for 5 cycles -> out_valid stays 1, outputs stable, in_ready=0, then handshake releases.
- Back-to-back frames: out_ready=1 and new first beat 9 in the same cycle as handshake -> accepted, no bubble; second frame {9,3(last)} in max mode gives out_data=9, out_idx=0.
- IDX_W=2: 5-beat frame {1,2,3,4,0(last)}, max -> out_data=4, out_idx=3, out_count=1, out_ovf=1.
- rst pulsed mid-frame after 2 beats -> out_valid=0, busy=0; next frame {6(last)} -> out_data=6, out_count=1.
